// File: rtl/mem_responder.sv
// mem_responder
// -------------
// Single-outstanding-request word memory with a fixed access latency.
// A request is captured in IDLE, waits LATENCY cycles in WAIT, and the
// array access happens on the edge that leaves WAIT. The following DONE
// cycle presents a one-cycle Ready strobe together with Err.
//
// Ports
//   Clk      : clock, all state changes on the rising edge
//   Reset    : synchronous active-high reset (clears the FSM, outputs and array)
//   Req      : access request, only honoured in IDLE
//   Wr       : 1 = write, 0 = read, captured with Req
//   Address  : byte address, captured with Req
//   DataIn   : write data, captured with Req
//   DataOut  : registered read data, held until the next valid read completes
//   Ready    : one-cycle completion strobe (DONE)
//   Busy     : high while a request is in flight (WAIT or DONE)
//   Err      : misaligned/out-of-range flag for the completing request
module mem_responder #(
    parameter int LATENCY   = 2,
    parameter int ADDR_BITS = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ready,
    output logic        Busy,
    output logic        Err
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 nextState_s;
    logic                   accept_s;
    logic                   access_s;
    logic                   badAddr_s;
    logic [3:0]             cnt_r;
    logic                   capWr_r;
    logic [ADDR_BITS-1:0]   capIdx_r;
    logic [31:0]            capData_r;
    logic                   capErr_r;
    logic [31:0]            memArray_r [DEPTH];

    // Address legality, evaluated on the live inputs so it can be captured with the request
    always_comb begin
        badAddr_s = (Address[1:0] != 2'b00) || (Address[31:ADDR_BITS+2] != '0);
    end

    // Next-state logic plus the accept/access strobes that drive the datapath
    always_comb begin
        nextState_s = state_r;
        accept_s    = 1'b0;
        access_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (Req) begin
                    nextState_s = WAIT;
                    accept_s    = 1'b1;
                end else begin
                    nextState_s = IDLE;
                end
            end
            WAIT: begin
                // The access edge is the one on which the counter has already reached zero
                if (cnt_r == 4'd0) begin
                    nextState_s = DONE;
                    access_s    = 1'b1;
                end else begin
                    nextState_s = WAIT;
                end
            end
            DONE: begin
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State register, latency counter, request capture and registered status outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            capWr_r   <= 1'b0;
            capIdx_r  <= '0;
            capData_r <= 32'd0;
            capErr_r  <= 1'b0;
            Ready     <= 1'b0;
            Busy      <= 1'b0;
            Err       <= 1'b0;
        end else begin
            state_r <= nextState_s;
            if (accept_s) begin
                cnt_r     <= CNT_LOAD;
                capWr_r   <= Wr;
                capIdx_r  <= Address[ADDR_BITS+1:2];
                capData_r <= DataIn;
                capErr_r  <= badAddr_s;
            end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            // Outputs are flops loaded from the next state so they line up with DONE exactly
            Ready <= (nextState_s == DONE);
            Busy  <= (nextState_s != IDLE);
            Err   <= (nextState_s == DONE) && capErr_r;
        end
    end

    // Word array and read-data register; an erroneous request touches neither
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                memArray_r[i] <= 32'd0;
            end
            DataOut <= 32'd0;
        end else if (access_s && !capErr_r) begin
            if (capWr_r) begin
                memArray_r[capIdx_r] <= capData_r;
            end else begin
                DataOut <= memArray_r[capIdx_r];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 1;
    localparam int AB    = 6;
    localparam int WORDS = 64;

    logic        Clk     = 1'b0;
    logic        Reset   = 1'b1;
    logic        Req     = 1'b0;
    logic        reqB    = 1'b0;
    logic        Wr      = 1'b0;
    logic [31:0] Address = 32'd0;
    logic [31:0] DataIn  = 32'd0;

    logic [31:0] doutA, doutB;
    logic        readyA, busyA, errA;
    logic        readyB, busyB, errB;

    mem_responder #(.LATENCY(LAT_A), .ADDR_BITS(AB)) dutA (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Address(Address),
        .DataIn(DataIn), .DataOut(doutA), .Ready(readyA), .Busy(busyA), .Err(errA)
    );

    mem_responder #(.LATENCY(LAT_B), .ADDR_BITS(AB)) dutB (
        .Clk(Clk), .Reset(Reset), .Req(reqB), .Wr(Wr), .Address(Address),
        .DataIn(DataIn), .DataOut(doutB), .Ready(readyB), .Busy(busyB), .Err(errB)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        qA[$];
    exp_t        qB[$];
    logic [31:0] refMem [2][WORDS];
    logic [31:0] refOut [2];
    int unsigned cyc   = 0;
    int          nVec  = 0;
    int          nFail = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < WORDS; i++) refMem[d][i] = 32'd0;
            refOut[d] = 32'd0;
        end
        qA.delete();
        qB.delete();
    endtask

    // Behavioural memory: whole-word access, bad addresses change nothing
    task automatic modelAccess(input int d, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input int unsigned doneCyc,
                               output exp_t e);
        bit bad;
        int idx;
        bad = (addr % 4 != 0) || (addr >= 4 * WORDS);
        idx = (addr / 4) % WORDS;
        if (!bad) begin
            if (wr) refMem[d][idx] = data;
            else    refOut[d] = refMem[d][idx];
        end
        e.cyc  = doneCyc;
        e.err  = bad;
        e.data = refOut[d];
    endtask

    // One-cycle request pulse; inputs are scrambled afterwards so only captured values matter
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data, input bit both);
        exp_t e;
        @(negedge Clk);
        Req = 1'b1; reqB = both; Wr = wr; Address = addr; DataIn = data;
        modelAccess(0, wr, addr, data, cyc + 1 + LAT_A, e);
        qA.push_back(e);
        if (both) begin
            modelAccess(1, wr, addr, data, cyc + 1 + LAT_B, e);
            qB.push_back(e);
        end
        @(negedge Clk);
        Req = 1'b0; reqB = 1'b0;
        Wr = 1'($urandom); Address = $urandom; DataIn = $urandom;
        repeat (LAT_A + 2) @(negedge Clk);
    endtask

    task automatic checkResetState();
        check32("A.reset.Ready", readyA, 0);
        check32("A.reset.Busy", busyA, 0);
        check32("A.reset.Err", errA, 0);
        check32("A.reset.DataOut", doutA, 0);
        check32("B.reset.Ready", readyB, 0);
        check32("B.reset.Busy", busyB, 0);
        check32("B.reset.Err", errB, 0);
        check32("B.reset.DataOut", doutB, 0);
    endtask

    // Monitor for the LATENCY=2 instance
    always @(negedge Clk) begin : monA
        exp_t e;
        if (!Reset) begin
            if (readyA) begin
                if (qA.size() == 0) begin
                    nVec++; nFail++;
                    $display("FAIL A.spuriousReady: got Ready=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = qA.pop_front();
                    check32("A.readyCycle", cyc, e.cyc);
                    check32("A.Err", errA, e.err);
                    check32("A.DataOut", doutA, e.data);
                    check32("A.busyAtReady", busyA, 1);
                end
            end else begin
                check32("A.errOutsideDone", errA, 0);
                if (qA.size() != 0 && cyc > qA[0].cyc) begin
                    e = qA.pop_front();
                    nVec++; nFail++;
                    $display("FAIL A.missedReady: got none expected Ready at cycle %0d (now %0d)", e.cyc, cyc);
                end
            end
        end
    end

    // Monitor for the LATENCY=1 instance
    always @(negedge Clk) begin : monB
        exp_t e;
        if (!Reset) begin
            if (readyB) begin
                if (qB.size() == 0) begin
                    nVec++; nFail++;
                    $display("FAIL B.spuriousReady: got Ready=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = qB.pop_front();
                    check32("B.readyCycle", cyc, e.cyc);
                    check32("B.Err", errB, e.err);
                    check32("B.DataOut", doutB, e.data);
                    check32("B.busyAtReady", busyB, 1);
                end
            end else begin
                check32("B.errOutsideDone", errB, 0);
                if (qB.size() != 0 && cyc > qB[0].cyc) begin
                    e = qB.pop_front();
                    nVec++; nFail++;
                    $display("FAIL B.missedReady: got none expected Ready at cycle %0d (now %0d)", e.cyc, cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned c0;
        logic [31:0] a;
        exp_t        e;
        localparam int P = LAT_A + 2;
        localparam int K = 5;

        modelReset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checkResetState();
        Reset = 1'b0;

        // Write then read back
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        issue(1'b0, 32'h0000_0010, $urandom, 1'b1);
        // Misaligned read and write leave data and array alone
        issue(1'b0, 32'h0000_0012, $urandom, 1'b1);
        issue(1'b1, 32'h0000_0013, 32'hCAFE_F00D, 1'b1);
        issue(1'b0, 32'h0000_0010, $urandom, 1'b1);
        // Out-of-range write must not alias onto word 0
        issue(1'b1, 32'h0000_0000, 32'hA5A5_0001, 1'b1);
        issue(1'b1, 32'h0000_0100, 32'h5A5A_5A5A, 1'b1);
        issue(1'b0, 32'h0000_0000, $urandom, 1'b1);
        issue(1'b0, 32'h8000_0004, $urandom, 1'b1);

        // Random mix of valid, misaligned and out-of-range accesses
        for (int n = 0; n < 150; n++) begin
            int r;
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, WORDS - 1)) << 2;
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            if (r == 1) a = a | (32'($urandom_range(1, 1000)) << (AB + 2));
            issue(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
        end

        // Reset during WAIT of a write aborts it
        @(negedge Clk);
        Req = 1'b1; reqB = 1'b1; Wr = 1'b1; Address = 32'h0000_0004; DataIn = 32'h1234_5678;
        @(negedge Clk);
        Req = 1'b0; reqB = 1'b0; Reset = 1'b1;
        @(negedge Clk);
        modelReset();
        checkResetState();
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        issue(1'b0, 32'h0000_0004, $urandom, 1'b1);

        // Req held high on the LATENCY=2 instance: one Ready every P cycles, Busy low once per period
        issue(1'b1, 32'h0000_0010, 32'h0BAD_CAFE, 1'b1);
        @(negedge Clk);
        c0 = cyc;
        Req = 1'b1; reqB = 1'b0; Wr = 1'b0; Address = 32'h0000_0010;
        for (int k = 0; k < K; k++) begin
            modelAccess(0, 1'b0, 32'h0000_0010, 32'd0, c0 + 1 + LAT_A + k * P, e);
            qA.push_back(e);
        end
        for (int j = 0; j < K * P; j++) begin
            if (j > 0) @(negedge Clk);
            check32("A.heldReq.Busy", busyA, (j % P) != 0);
            if (j == (K - 1) * P + 1) Req = 1'b0;
        end
        repeat (10) @(negedge Clk);

        check32("A.queueDrained", qA.size(), 0);
        check32("B.queueDrained", qB.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, giving the number of wait cycles between request acceptance and data access (legal range 1..15).
REQ-002 The block SHALL have parameter ADDR_BITS, default 6, giving word-array depth 2^ADDR_BITS words of 32 bits.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Req, input, 1 bit: the initiator requests an access.
REQ-006 The block SHALL have port Wr, input, 1 bit: 1 = write, 0 = read, sampled with Req.
REQ-007 The block SHALL have port Address, input, 32 bits: byte address, sampled with Req.
REQ-008 The block SHALL have port DataIn, input, 32 bits: write data, sampled with Req.
REQ-009 The block SHALL have port DataOut, output, 32 bits: read data, registered.
REQ-010 The block SHALL have port Ready, output, 1 bit: one-cycle response strobe.
REQ-011 The block SHALL have port Busy, output, 1 bit: high while a request is in flight (WAIT or DONE).
REQ-012 The block SHALL have port Err, output, 1 bit: error flag for the completing request, valid while Ready = 1.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT, and DONE.
REQ-014 In IDLE with Req = 1, the block SHALL capture Wr, Address, and DataIn, load the 4-bit counter with LATENCY-1, and enter WAIT on the next edge.
REQ-015 In WAIT, the counter SHALL decrement each cycle; when the counter equals 0, the access SHALL be performed at that edge and the state SHALL become DONE.
REQ-016 Timing: if accepted in cycle T, WAIT SHALL occupy T+1..T+LATENCY, DONE (Ready = 1) SHALL be cycle T+LATENCY+1, and IDLE SHALL be T+LATENCY+2.
REQ-017 Ready SHALL be high for exactly one cycle per accepted request and only in DONE.
REQ-018 Busy SHALL be 1 in WAIT and DONE and 0 in IDLE.
REQ-019 Req SHALL be ignored in WAIT and DONE; there SHALL be no queuing, so a Req held high is accepted again only in the next IDLE cycle.
REQ-020 Word index SHALL be Address[ADDR_BITS+1:2], and only whole 32-bit words SHALL be transferred.
REQ-021 A request SHALL be misaligned when Address[1:0] != 0, and out of range when Address[31:ADDR_BITS+2] != 0.
REQ-022 A misaligned or out-of-range request SHALL set Err = 1 in DONE, SHALL NOT modify the array, and SHALL leave DataOut unchanged.
REQ-023 A valid read SHALL load DataOut with array[index] at the access edge, and DataOut SHALL be held until the next valid read completes.
REQ-024 A valid write SHALL store the captured DataIn into array[index] at the access edge, and DataOut SHALL be unchanged.
REQ-025 A write followed by a read of the same word SHALL return the written value (no stale data).
REQ-026 Err SHALL be 0 outside DONE.

Reset
REQ-027 While Reset = 1 at an edge, state SHALL go to IDLE, counter to 0, Ready/Busy/Err to 0, DataOut to 0, and all array words to 0.
REQ-028 Reset asserted mid-request (WAIT or DONE) SHALL abort the request: no array write, no Ready pulse.
REQ-029 Reset SHALL take priority over Req in the same cycle.

Verification
REQ-030 Write then read, LATENCY = 2: write 0xDEADBEEF to 0x00000010 accepted at T -> Ready at T+3, Err = 0; then read 0x10 -> DataOut = 0xDEADBEEF with Ready.
REQ-031 Misaligned access: read 0x00000012 -> Err = 1 with Ready, DataOut keeps its prior value; write 0x13 leaves the word at 0x10 unchanged.
REQ-032 Out-of-range access: write to 0x00000100 (ADDR_BITS = 6) -> Err = 1 and no array change; read of 0x0 still returns the prior content.
REQ-033 Req held high continuously: Ready pulses once every LATENCY+2 cycles (4 for default), and Busy is low exactly one cycle between pulses.
REQ-034 Reset mid-WAIT of a write of 0x12345678 to 0x4 -> no Ready; subsequent read of 0x4 returns 0x00000000.
REQ-035 LATENCY = 1 build: request accepted at T -> Ready at T+2, and data is correct for both read and write.
